// File: rtl/axis_pacer_pkg.sv
// Shared definitions for the AXIS sample pacer: state encoding and prime-level clamping.
package axis_pacer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRIME    = 2'd1,
    ST_RUN      = 2'd2,
    ST_UNDERRUN = 2'd3
  } pacer_state_e;

  // Zero would never start output; anything above the FIFO depth could never be reached.
  function automatic int unsigned clamp_prime(input int unsigned lvl, input int unsigned depth);
    if (lvl == 0) return 1;
    if (lvl > depth) return depth;
    return lvl;
  endfunction

endpackage

// File: rtl/axis_pacer_fifo.sv
// First-word-fall-through FIFO: dout always shows the oldest word while not empty.
module axis_pacer_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/axis_sample_pacer.sv
// Buffers ring words and releases one per programmed sample period to the DAC register.
//   state    | meaning
//   IDLE     | stopped, FIFO flushed, outputs holding
//   PRIME    | filling FIFO up to the latched prime level
//   RUN      | one pop per tick of the sample-period timer
//   UNDERRUN | FIFO was empty at a tick; re-prime next cycle
module axis_sample_pacer
  import axis_pacer_pkg::*;
#(
  parameter int TDATA_WIDTH = 64,
  parameter int DIV_WIDTH   = 16,
  parameter int FIFO_DEPTH  = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic                         enable,
  input  logic [DIV_WIDTH-1:0]         cfg_divider,
  input  logic [$clog2(FIFO_DEPTH):0]  cfg_prime_level,
  input  logic [TDATA_WIDTH-1:0]       s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  output logic [TDATA_WIDTH-1:0]       dac_data,
  output logic                         dac_strobe,
  output logic                         underrun,
  output logic [CNT_WIDTH-1:0]         sample_count,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic [1:0]                   state
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  pacer_state_e           st_q, st_nx;
  logic [DIV_WIDTH-1:0]   div_q;
  logic [DIV_WIDTH-1:0]   tick_cnt;
  logic [LW-1:0]          prime_q;
  logic [LW-1:0]          level_nx;
  logic [TDATA_WIDTH-1:0] fifo_dout;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   flush;
  logic                   start;
  logic                   tick;
  logic                   do_push;
  logic                   do_pop;

  assign state   = st_q;
  assign flush   = ~enable;
  assign start   = (st_q == ST_IDLE) & enable;
  assign tick    = (st_q == ST_RUN) & enable & (tick_cnt == '0);
  assign do_pop  = tick & ~fifo_empty;
  assign do_push = s_axis_tvalid & s_axis_tready & ~fifo_full & ~flush;

  axis_pacer_fifo #(
    .WIDTH (TDATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .aclk   (aclk),
    .areset (areset),
    .flush  (flush),
    .push   (do_push),
    .pop    (do_pop),
    .din    (s_axis_tdata),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

  always_comb begin
    st_nx    = st_q;
    level_nx = fifo_level;
    if (!enable) begin
      st_nx = ST_IDLE;
    end else begin
      case (st_q)
        ST_IDLE:     st_nx = ST_PRIME;
        ST_PRIME:    if (fifo_level >= prime_q) st_nx = ST_RUN;
        ST_RUN:      if (tick && fifo_empty) st_nx = ST_UNDERRUN;
        ST_UNDERRUN: st_nx = ST_PRIME;
        default:     st_nx = ST_IDLE;
      endcase
    end
    // Occupancy after this edge, so the registered ready never admits a word into a full FIFO.
    if (flush) begin
      level_nx = '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   level_nx = fifo_level + LW'(1);
        2'b01:   level_nx = fifo_level - LW'(1);
        default: level_nx = fifo_level;
      endcase
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      st_q          <= ST_IDLE;
      div_q         <= '0;
      prime_q       <= '0;
      tick_cnt      <= '0;
      s_axis_tready <= 1'b0;
      dac_data      <= '0;
      dac_strobe    <= 1'b0;
      underrun      <= 1'b0;
      sample_count  <= '0;
    end else begin
      st_q          <= st_nx;
      s_axis_tready <= enable & (st_nx != ST_IDLE) & (level_nx != FULL_LVL);
      dac_strobe    <= do_pop;
      if (do_pop) begin
        dac_data     <= fifo_dout;
        sample_count <= sample_count + CNT_WIDTH'(1);
      end
      if (start) begin
        div_q        <= cfg_divider;
        prime_q      <= LW'(clamp_prime(32'(cfg_prime_level), FIFO_DEPTH));
        underrun     <= 1'b0;
        sample_count <= '0;
      end
      if (tick && fifo_empty) underrun <= 1'b1;
      // Down-counter reloaded with the period; terminal count zero is the tick.
      if (st_q != ST_RUN)        tick_cnt <= div_q;
      else if (tick_cnt == '0)   tick_cnt <= div_q;
      else                       tick_cnt <= tick_cnt - DIV_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_axis_sample_pacer.sv
// Scoreboard bench for axis_sample_pacer: source words are queued on handshake, strobes are popped and compared.
module tb_axis_sample_pacer;

  localparam int TW = 64;
  localparam int DW = 16;
  localparam int LW = 5;
  localparam int CW = 32;
  localparam logic [1:0] S_IDLE = 2'd0, S_PRIME = 2'd1, S_RUN = 2'd2, S_UNDER = 2'd3;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          enable = 1'b1;
  logic [DW-1:0] cfg_divider = '0;
  logic [LW-1:0] cfg_prime_level = '0;
  logic [TW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [TW-1:0] dac_data;
  logic          dac_strobe;
  logic          underrun;
  logic [CW-1:0] sample_count;
  logic [LW-1:0] fifo_level;
  logic [1:0]    state;

  int            tests = 0;
  int            fails = 0;
  int            cyc = 0;
  int            src_mode = 0;
  logic [TW-1:0] nxt = 64'd1;
  logic [TW-1:0] exp_q[$];
  logic [TW-1:0] last_data = '0;
  int            strobe_cnt = 0;
  int            per_chk = 0;
  int            exp_gap = 0;
  int            last_cyc = -1;

  axis_sample_pacer dut (
    .aclk            (aclk),
    .areset          (areset),
    .enable          (enable),
    .cfg_divider     (cfg_divider),
    .cfg_prime_level (cfg_prime_level),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .dac_data        (dac_data),
    .dac_strobe      (dac_strobe),
    .underrun        (underrun),
    .sample_count    (sample_count),
    .fifo_level      (fifo_level),
    .state           (state)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Source: 0 idle, 1 always valid, 2 valid one cycle in two
  initial begin
    logic hs;
    forever begin
      @(negedge aclk);
      hs = s_axis_tvalid && s_axis_tready;
      @(posedge aclk);
      #1;
      if (hs) begin
        exp_q.push_back(s_axis_tdata);
        nxt = nxt + 64'd1;
      end
      case (src_mode)
        1:       s_axis_tvalid = 1'b1;
        2:       s_axis_tvalid = !hs;
        default: s_axis_tvalid = 1'b0;
      endcase
      s_axis_tdata = nxt;
    end
  end

  // Monitor: every strobe must carry the oldest accepted word
  initial begin
    logic [TW-1:0] e;
    forever begin
      @(negedge aclk);
      if (!areset && dac_strobe) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_empty: strobe with dac_data=%0h, required no strobe", dac_data);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", dac_data, e);
          last_data = e;
        end
        strobe_cnt++;
        if (per_chk != 0 && last_cyc >= 0) chk("period", 64'(cyc - last_cyc), 64'(exp_gap));
        last_cyc = cyc;
      end
    end
  end

  task automatic wait_state(input logic [1:0] s, input int budget, input string nm);
    int n = 0;
    while (state !== s && n < budget) begin
      @(negedge aclk);
      n++;
    end
    if (state !== s) chk(nm, 64'(state), 64'(s));
  endtask

  task automatic wait_level(input logic [LW-1:0] l, input int budget, input string nm);
    int n = 0;
    while (fifo_level !== l && n < budget) begin
      @(negedge aclk);
      n++;
    end
    if (fifo_level !== l) chk(nm, 64'(fifo_level), 64'(l));
  endtask

  // Records level and ready in the last PRIME cycle before RUN
  task automatic wait_run(output int plev, output logic ptr);
    int n = 0;
    plev = -1;
    ptr  = 1'bx;
    while (state !== S_RUN && n < 100) begin
      plev = int'(fifo_level);
      ptr  = s_axis_tready;
      @(negedge aclk);
      n++;
    end
    if (state !== S_RUN) chk("run_timeout", 64'(state), 64'(S_RUN));
  endtask

  task automatic start_run(input logic [DW-1:0] dv, input logic [LW-1:0] pl, input int mode, input int gap);
    cfg_divider     = dv;
    cfg_prime_level = pl;
    strobe_cnt      = 0;
    last_cyc        = -1;
    per_chk         = (gap > 0) ? 1 : 0;
    exp_gap         = gap;
    src_mode        = mode;
    enable          = 1'b1;
    @(negedge aclk);
    chk("start_state", 64'(state), 64'(S_PRIME));
    chk("start_underrun", 64'(underrun), 64'd0);
    chk("start_count", 64'(sample_count), 64'd0);
  endtask

  task automatic stop_run();
    src_mode = 0;
    repeat (2) @(negedge aclk);
    enable = 1'b0;
    @(negedge aclk);
    exp_q.delete();
    chk("stop_state", 64'(state), 64'(S_IDLE));
  endtask

  initial begin
    int   plev;
    logic ptr;
    int   n;
    int   k;

    // Reset with the run request and source already active
    cfg_divider     = 16'd3;
    cfg_prime_level = 5'd4;
    s_axis_tdata    = 64'd1;
    s_axis_tvalid   = 1'b1;
    src_mode        = 1;
    exp_gap         = 4;
    per_chk         = 1;
    repeat (3) @(negedge aclk);
    chk("rst_state", 64'(state), 64'(S_IDLE));
    chk("rst_tready", 64'(s_axis_tready), 64'd0);
    chk("rst_dac_data", dac_data, 64'd0);
    chk("rst_strobe", 64'(dac_strobe), 64'd0);
    chk("rst_underrun", 64'(underrun), 64'd0);
    chk("rst_count", 64'(sample_count), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    areset = 1'b0;
    @(negedge aclk);
    chk("rel_state", 64'(state), 64'(S_PRIME));
    chk("rel_tready", 64'(s_axis_tready), 64'd1);

    // div=3, prime=4: RUN after 4 words, strobe every 4 cycles with 1,2,3,...
    wait_run(plev, ptr);
    chk("prime4_level", 64'(plev), 64'd4);
    n = 0;
    k = 0;
    while (n < 10 && k < 200) begin
      @(negedge aclk);
      k++;
      if (dac_strobe) n++;
    end
    chk("ten_strobes", 64'(n), 64'd10);
    chk("count10", 64'(sample_count), 64'd10);
    chk("no_underrun", 64'(underrun), 64'd0);
    chk("run_state", 64'(state), 64'(S_RUN));

    // Drain to 5 words, then drop the run request
    src_mode = 0;
    wait_level(5'd5, 200, "drain_to5");
    enable = 1'b0;
    @(negedge aclk);
    chk("drop_state", 64'(state), 64'(S_IDLE));
    chk("drop_level", 64'(fifo_level), 64'd0);
    chk("drop_strobe", 64'(dac_strobe), 64'd0);
    chk("drop_hold_data", dac_data, last_data);
    chk("drop_hold_count", 64'(sample_count), 64'(strobe_cnt));
    exp_q.delete();

    // Restart with div=7; later cfg edits must not matter; source outruns sink so FIFO fills
    start_run(16'd7, 5'd4, 1, 8);
    cfg_divider     = 16'd0;
    cfg_prime_level = 5'd1;
    wait_run(plev, ptr);
    chk("reprime_level", 64'(plev), 64'd4);
    wait_level(5'd16, 100, "fill16");
    chk("full_tready", 64'(s_axis_tready), 64'd0);
    repeat (40) @(negedge aclk);
    chk("div7_underrun", 64'(underrun), 64'd0);
    stop_run();

    // div=0, prime=2, half-rate source: underrun, then re-prime and resume
    start_run(16'd0, 5'd2, 2, 0);
    wait_state(S_UNDER, 100, "reach_underrun");
    chk("ur_flag", 64'(underrun), 64'd1);
    chk("ur_strobe", 64'(dac_strobe), 64'd0);
    chk("ur_hold_data", dac_data, last_data);
    @(negedge aclk);
    chk("ur_next_state", 64'(state), 64'(S_PRIME));
    chk("ur_sticky", 64'(underrun), 64'd1);
    n = 0;
    k = 0;
    while (n < 1 && k < 50) begin
      @(negedge aclk);
      k++;
      if (dac_strobe) n++;
    end
    chk("ur_resume", 64'(n), 64'd1);
    chk("ur_still_set", 64'(underrun), 64'd1);
    stop_run();

    // Prime level 0 behaves as 1; 31 clamps to the depth of 16
    start_run(16'd15, 5'd0, 1, 0);
    wait_run(plev, ptr);
    chk("prime0_level", 64'(plev), 64'd1);
    stop_run();
    start_run(16'd15, 5'd31, 1, 0);
    wait_run(plev, ptr);
    chk("prime31_level", 64'(plev), 64'd16);
    chk("prime31_tready", 64'(ptr), 64'd0);
    stop_run();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axis_sample_pacer.md
Name: axis_sample_pacer

Overview:
- Sits directly downstream of the RAM reader's AXIS master output (m_axis_*). Consumes 64-bit words read back from the DMA ring.
- Buffers words in a small FIFO and releases one word per programmable sample period to a DAC-facing register.
- Primes the FIFO before starting, and flags underrun when the ring cannot keep pace.
- Gives the flow-control logic and software a deterministic output rate and a sample counter.

Parameters:
- TDATA_WIDTH, 64, width of input stream word and output sample.
- DIV_WIDTH, 16, width of the sample-period divider.
- FIFO_DEPTH, 16, internal buffer depth in words; must be a power of 2 and at least 2.
- CNT_WIDTH, 32, width of the emitted-sample counter.

Ports:
- aclk  in  1  system clock; all logic on the rising edge.
- areset  in  1  asynchronous, active-high reset.
- enable  in  1  run request; level-sensitive.
- cfg_divider  in  DIV_WIDTH  sample period minus 1, in aclk cycles.
- cfg_prime_level  in  $clog2(FIFO_DEPTH)+1  FIFO words required before output starts.
- s_axis_tdata  in  TDATA_WIDTH  stream word from the RAM reader.
- s_axis_tvalid  in  1  stream valid.
- s_axis_tready  out  1  stream ready.
- dac_data  out  TDATA_WIDTH  current output sample (registered).
- dac_strobe  out  1  one-cycle pulse when dac_data updates.
- underrun  out  1  sticky flag: the FIFO was empty at a sample tick.
- sample_count  out  CNT_WIDTH  samples emitted since the last start.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- state  out  2  current state: 0 IDLE, 1 PRIME, 2 RUN, 3 UNDERRUN.

Behaviour:
- Reset (areset=1, asynchronous):
  - state=IDLE; FIFO empty.
  - dac_data=0, dac_strobe=0, underrun=0, sample_count=0, fifo_level=0, s_axis_tready=0.
  - Tick counter=0; latched config=0.
- Handshake:
  - s_axis_tready = enable & ~fifo_full & (state!=IDLE), all terms registered.
  - A word is pushed on the cycle tvalid&tready=1.
  - No push while full, even if a pop occurs in the same cycle.
- Latched configuration:
  - On the IDLE->PRIME transition, cfg_divider and cfg_prime_level are captured into internal registers.
  - Changes to cfg_* have no effect until the next start.
  - A latched prime level of 0 is treated as 1; values above FIFO_DEPTH are clamped to FIFO_DEPTH.
- Tick counter:
  - Runs only in RUN; counts 0..div.
  - tick=1 when count==div, then the counter wraps to 0.
  - Sample period = div+1 cycles; div=0 gives a tick every cycle.
  - The first tick occurs div+1 cycles after entering RUN.
- IDLE:
  - Entered when enable=0, from any state, on the next cycle.
  - On entry, the FIFO is flushed, the counter is cleared and dac_strobe=0.
  - dac_data, sample_count and underrun hold their values.
  - enable=1 -> PRIME; on that transition underrun and sample_count clear to 0.
- PRIME:
  - Accepts words; no ticks.
  - When fifo_level >= latched prime level -> RUN, with counter=0.
- RUN:
  - On a tick with FIFO non-empty: pop; next cycle dac_data=popped word, dac_strobe=1, sample_count+1 (wraps modulo 2^CNT_WIDTH).
  - Pop-to-output latency is 1 cycle.
  - On a tick with FIFO empty: no pop, dac_strobe stays 0, dac_data holds, underrun<=1, state -> UNDERRUN.
- UNDERRUN:
  - Counter cleared; underrun stays 1.
  - Next cycle -> PRIME (re-prime with the latched level); underrun remains set until the next IDLE->PRIME start.
- Simultaneous push and pop in RUN: both occur and fifo_level is unchanged. This applies only when the FIFO is not full before the cycle.
- Reset mid-operation: the FIFO contents are lost; no strobe is generated on reset release.

Decomposition:
- Shared package axis_pacer_pkg holds:
  - the state encoding constants ST_IDLE=0, ST_PRIME=1, ST_RUN=2, ST_UNDERRUN=3;
  - a function for prime-level clamping.
- One sub-module, axis_pacer_fifo: synchronous FWFT FIFO with parameters WIDTH and DEPTH.
  - Ports: push, pop, din, dout, full, empty, level, flush.
  - Asynchronous active-high reset.

Test Plan:
- Reset with enable=1 and tvalid=1 -> all outputs 0, tready=0; after release, state goes IDLE->PRIME and tready=1 on the following cycle.
- div=3, prime=4, source always valid with words 1,2,3,...:
  - RUN is entered after 4 pushes.
  - dac_strobe pulses every 4 cycles with dac_data=1,2,3,...
  - sample_count=10 after 10 strobes; underrun=0.
- div=0, prime=2, source valid 1 cycle in 2 -> first tick after prime drains the FIFO; underrun=1, state passes UNDERRUN->PRIME and output resumes after re-prime. dac_data holds the last value during the gap.
- Source always valid, sink div=7 -> FIFO fills to 16, tready=0 while full, no word lost or duplicated (scoreboard matches the input sequence).
- enable dropped in RUN with fifo_level=5 -> IDLE next cycle, fifo_level=0, dac_data holds. Re-enable -> underrun=0, sample_count=0, the latched new cfg_divider is used.
- cfg_prime_level=0 and =31 with FIFO_DEPTH=16 -> RUN is entered at levels 1 and 16 respectively.
